mem_bridge: RTL and testbench

MEM_BRIDGE -- requirements
Module: mem_bridge

---
 rtl/mem_bridge.sv | 135 +++++++++++++
 tb/tb_mem_bridge.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bridge.sv
// Byte-serial bridge: splits 1/2/4/6-byte CPU accesses into single-byte memory cycles.
// Optional watchdog abort with bus_err when MEM_BRIDGE_TIMEOUT_EN is defined.
module mem_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_valid,
    input  logic                  cpu_req_we,
    input  logic [1:0]            cpu_req_size,
    input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
    input  logic [47:0]           cpu_req_wdata,
    output logic                  cpu_enable,
    output logic [47:0]           cpu_data_in,
    output logic                  bus_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_re,
    output logic                  mem_we,
    input  logic [7:0]            mem_rdata,
    input  logic                  mem_ready
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state;
    logic        we;
    logic [2:0]  k;
    logic [2:0]  last;
    logic [39:0] wdata_hi;
    logic [47:0] rbuf;
    logic [47:0] rbuf_merged;
    logic [2:0]  size_last;

`ifdef MEM_BRIDGE_TIMEOUT_EN
    logic [31:0] wait_cnt;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign bus_err = 1'b0;
`endif

    always_comb begin
        size_last = 3'd0;
        case (cpu_req_size)
            2'b00:   size_last = 3'd0;
            2'b01:   size_last = 3'd1;
            2'b10:   size_last = 3'd3;
            default: size_last = 3'd5;
        endcase
    end

    assign rbuf_merged = rbuf | ({40'd0, mem_rdata} << {k, 3'b000});

    assign cpu_enable = (state == DONE) || ((state == IDLE) && !cpu_req_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            we          <= 1'b0;
            k           <= 3'd0;
            last        <= 3'd0;
            wdata_hi    <= 40'd0;
            rbuf        <= 48'd0;
            cpu_data_in <= 48'd0;
            mem_addr    <= '0;
            mem_wdata   <= 8'd0;
            mem_re      <= 1'b0;
            mem_we      <= 1'b0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
            wait_cnt    <= 32'd0;
            bus_err     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req_valid) begin
                        state     <= ACCESS;
                        we        <= cpu_req_we;
                        k         <= 3'd0;
                        last      <= size_last;
                        wdata_hi  <= cpu_req_wdata[47:8];
                        rbuf      <= 48'd0;
                        mem_addr  <= cpu_req_addr;
                        mem_re    <= !cpu_req_we;
                        mem_we    <= cpu_req_we;
                        mem_wdata <= cpu_req_we ? cpu_req_wdata[7:0] : 8'd0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
                        wait_cnt  <= 32'd0;
`endif
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
`ifdef MEM_BRIDGE_TIMEOUT_EN
                        wait_cnt <= 32'd0;
`endif
                        if (!we) rbuf <= rbuf_merged;
                        if (k == last) begin
                            state     <= DONE;
                            mem_re    <= 1'b0;
                            mem_we    <= 1'b0;
                            mem_wdata <= 8'd0;
                            if (!we) cpu_data_in <= rbuf_merged;
                        end else begin
                            k         <= k + 3'd1;
                            mem_addr  <= mem_addr + ADDR_WIDTH'(1);
                            mem_wdata <= we ? wdata_hi[7:0] : 8'd0;
                            wdata_hi  <= {8'd0, wdata_hi[39:8]};
                        end
`ifdef MEM_BRIDGE_TIMEOUT_EN
                    end else if (wait_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                        // Abort: keep whatever bytes arrived, the rest stay zero.
                        state     <= DONE;
                        bus_err   <= 1'b1;
                        mem_re    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wdata <= 8'd0;
                        if (!we) cpu_data_in <= rbuf;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
`ifdef MEM_BRIDGE_TIMEOUT_EN
                    bus_err <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed self-checking bench for mem_bridge; define MEM_BRIDGE_TIMEOUT_EN to add the timeout scenario.
module tb_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req_valid;
    logic        cpu_req_we;
    logic [1:0]  cpu_req_size;
    logic [31:0] cpu_req_addr;
    logic [47:0] cpu_req_wdata;
    logic        cpu_enable;
    logic [47:0] cpu_data_in;
    logic        bus_err;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;

`ifdef MEM_BRIDGE_TIMEOUT_EN
    mem_bridge #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
`else
    mem_bridge #(.ADDR_WIDTH(32)) dut (
`endif
        .clk(clk), .rst(rst), .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we),
        .cpu_req_size(cpu_req_size), .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_enable(cpu_enable), .cpu_data_in(cpu_data_in), .bus_err(bus_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    // Small memory image for reads.
    always_comb begin
        case (mem_addr)
            32'h100: mem_rdata = 8'h11;
            32'h101: mem_rdata = 8'h22;
            32'h102: mem_rdata = 8'h33;
            32'h103: mem_rdata = 8'h44;
            32'h200: mem_rdata = 8'hA5;
            default: mem_rdata = 8'h00;
        endcase
    end

    always @(negedge clk) if (bus_err === 1'b1) err_pulses++;

    task automatic test_reset();
        rst = 1'b1; cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_size = 2'b00;
        cpu_req_addr = 32'h0; cpu_req_wdata = 48'h0; mem_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (mem_re !== 1'b0 || mem_we !== 1'b0 || mem_wdata !== 8'h00) begin
            errors++; $display("FAIL reset_strobes got re=%b we=%b wd=%h want 0 0 00", mem_re, mem_we, mem_wdata);
        end
        checks++;
        if (mem_addr !== 32'h0 || cpu_data_in !== 48'h0 || bus_err !== 1'b0) begin
            errors++; $display("FAIL reset_regs got addr=%h din=%h berr=%b want 0", mem_addr, cpu_data_in, bus_err);
        end
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if (cpu_enable !== 1'b1) begin errors++; $display("FAIL reset_en_idle got %b want 1", cpu_enable); end
        cpu_req_valid = 1'b1; #1;
        checks++;
        if (cpu_enable !== 1'b0) begin errors++; $display("FAIL reset_en_req got %b want 0", cpu_enable); end
        cpu_req_valid = 1'b0; #1;
    endtask

    task automatic test_read4();
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_size = 2'b10; cpu_req_addr = 32'h100;
        mem_ready = 1'b1; #1;
        checks++;
        if (cpu_enable !== 1'b0) begin errors++; $display("FAIL read4_req_en got %b want 0", cpu_enable); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); cpu_req_valid = 1'b0; #1;
            checks++;
            if (mem_addr !== 32'(32'h100 + i) || mem_re !== 1'b1 || mem_we !== 1'b0 || cpu_enable !== 1'b0) begin
                errors++;
                $display("FAIL read4_byte%0d got addr=%h re=%b we=%b en=%b want %h 1 0 0",
                         i, mem_addr, mem_re, mem_we, cpu_enable, 32'(32'h100 + i));
            end
        end
        @(negedge clk); #1;
        checks++;
        if (cpu_enable !== 1'b1 || cpu_data_in !== 48'h000044332211 || mem_re !== 1'b0) begin
            errors++;
            $display("FAIL read4_done got en=%b din=%h re=%b want 1 000044332211 0", cpu_enable, cpu_data_in, mem_re);
        end
    endtask

    task automatic test_write6();
        logic [31:0] exp_addr [6];
        logic [7:0]  exp_byte [6];
        exp_addr = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h2, 32'h3};
        exp_byte = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_we = 1'b1; cpu_req_size = 2'b11; cpu_req_addr = 32'hFFFFFFFE;
        cpu_req_wdata = 48'h665544332211; mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); cpu_req_valid = 1'b0; #1;
            checks++;
            if (mem_addr !== exp_addr[i] || mem_wdata !== exp_byte[i] || mem_we !== 1'b1 || mem_re !== 1'b0) begin
                errors++;
                $display("FAIL write6_byte%0d got addr=%h wd=%h we=%b re=%b want %h %h 1 0",
                         i, mem_addr, mem_wdata, mem_we, mem_re, exp_addr[i], exp_byte[i]);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (cpu_enable !== 1'b1 || mem_we !== 1'b0 || mem_wdata !== 8'h00 || cpu_data_in !== 48'h000044332211) begin
            errors++;
            $display("FAIL write6_done got en=%b we=%b wd=%h din=%h want 1 0 00 000044332211",
                     cpu_enable, mem_we, mem_wdata, cpu_data_in);
        end
    endtask

    task automatic test_size2();
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_size = 2'b01; cpu_req_addr = 32'h102;
        mem_ready = 1'b1;
        repeat (2) begin @(negedge clk); cpu_req_valid = 1'b0; end
        @(negedge clk); #1;
        checks++;
        if (cpu_enable !== 1'b1 || cpu_data_in !== 48'h000000004433) begin
            errors++; $display("FAIL size2_done got en=%b din=%h want 1 000000004433", cpu_enable, cpu_data_in);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_size = 2'b00; cpu_req_addr = 32'h101;
        mem_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (mem_addr !== 32'h101 || mem_re !== 1'b1) begin
            errors++; $display("FAIL b2b_first got addr=%h re=%b want 101 1", mem_addr, mem_re);
        end
        @(negedge clk); cpu_req_addr = 32'h103; #1;
        checks++;
        if (cpu_enable !== 1'b1 || cpu_data_in !== 48'h22) begin
            errors++; $display("FAIL b2b_done1 got en=%b din=%h want 1 22", cpu_enable, cpu_data_in);
        end
        @(negedge clk); #1;
        checks++;
        if (cpu_enable !== 1'b0 || mem_re !== 1'b0) begin
            errors++; $display("FAIL b2b_idle got en=%b re=%b want 0 0", cpu_enable, mem_re);
        end
        @(negedge clk); cpu_req_valid = 1'b0; #1;
        checks++;
        if (mem_addr !== 32'h103 || mem_re !== 1'b1) begin
            errors++; $display("FAIL b2b_second got addr=%h re=%b want 103 1", mem_addr, mem_re);
        end
        @(negedge clk); #1;
        checks++;
        if (cpu_enable !== 1'b1 || cpu_data_in !== 48'h44) begin
            errors++; $display("FAIL b2b_done2 got en=%b din=%h want 1 44", cpu_enable, cpu_data_in);
        end
    endtask

    task automatic test_wait();
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_size = 2'b00; cpu_req_addr = 32'h200;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); cpu_req_valid = 1'b0; mem_ready = (i == 2); #1;
            checks++;
            if (mem_addr !== 32'h200 || mem_re !== 1'b1 || mem_we !== 1'b0 || cpu_enable !== 1'b0) begin
                errors++;
                $display("FAIL wait_cycle%0d got addr=%h re=%b we=%b en=%b want 200 1 0 0",
                         i, mem_addr, mem_re, mem_we, cpu_enable);
            end
        end
        @(negedge clk); mem_ready = 1'b1; #1;
        checks++;
        if (cpu_enable !== 1'b1 || cpu_data_in !== 48'h0000000000A5 || mem_re !== 1'b0) begin
            errors++; $display("FAIL wait_done got en=%b din=%h re=%b want 1 0000000000a5 0", cpu_enable, cpu_data_in, mem_re);
        end
    endtask

    task automatic test_reset_mid();
        int we_after;
        we_after = 0;
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_we = 1'b1; cpu_req_size = 2'b11; cpu_req_addr = 32'h10;
        cpu_req_wdata = 48'hAABBCCDDEEFF; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin @(negedge clk); cpu_req_valid = 1'b0; end
        #1;
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h12 || mem_wdata !== 8'hDD) begin
            errors++; $display("FAIL rstmid_pre got we=%b addr=%h wd=%h want 1 12 dd", mem_we, mem_addr, mem_wdata);
        end
        rst = 1'b1; #1;
        checks++;
        if (mem_we !== 1'b0 || mem_re !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 8'h00 || cpu_data_in !== 48'h0) begin
            errors++;
            $display("FAIL rstmid_async got we=%b re=%b addr=%h wd=%h din=%h want 0 0 0 00 0",
                     mem_we, mem_re, mem_addr, mem_wdata, cpu_data_in);
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            if (mem_we === 1'b1) we_after++;
        end
        checks++;
        if (we_after != 0 || cpu_enable !== 1'b1) begin
            errors++; $display("FAIL rstmid_after got writes=%0d en=%b want 0 1", we_after, cpu_enable);
        end
    endtask

`ifdef MEM_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_size = 2'b00; cpu_req_addr = 32'h100;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); cpu_req_valid = 1'b0; #1;
            checks++;
            if (mem_re !== 1'b1 || bus_err !== 1'b0 || cpu_enable !== 1'b0) begin
                errors++; $display("FAIL timeout_wait%0d got re=%b berr=%b en=%b want 1 0 0", i, mem_re, bus_err, cpu_enable);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (bus_err !== 1'b1 || cpu_enable !== 1'b1 || mem_re !== 1'b0 || cpu_data_in !== 48'h0) begin
            errors++;
            $display("FAIL timeout_done got berr=%b en=%b re=%b din=%h want 1 1 0 0", bus_err, cpu_enable, mem_re, cpu_data_in);
        end
        @(negedge clk); mem_ready = 1'b1; #1;
        checks++;
        if (bus_err !== 1'b0) begin errors++; $display("FAIL timeout_pulse got %b want 0", bus_err); end
    endtask
`else
    task automatic test_no_bus_err();
        checks++;
        if (err_pulses != 0) begin errors++; $display("FAIL bus_err_const got %0d pulses want 0", err_pulses); end
    endtask
`endif

    initial begin
        test_reset();
        test_read4();
        test_write6();
        test_size2();
        test_back_to_back();
        test_wait();
        test_reset_mid();
`ifdef MEM_BRIDGE_TIMEOUT_EN
        test_timeout();
`else
        test_no_bus_err();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
